// File: rtl/cpu_defs.sv
// Shared constants for the pipelined MIPS core: reset/NOP words and the
// next-PC select encoding used by the fetch stage.
package cpu_defs;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_HOLD   = 2'd3;

  // Redirect targets are word-truncated rather than trapped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: fetch drives a word index, memory answers
// combinationally in the same cycle.
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads, holds on stall, or inserts a bubble on
// flush; reports when a real instruction was accepted.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        count_en
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Flush outranks stall so a redirect always squashes the wrong-path word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_instr    <= instr;
      r_pc_plus4 <= pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign count_en      = !reset && !flush && !stall;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pc_plus4;
  assign ifid_valid    = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection (branch > jump > stall > +4),
// instruction memory addressing and the IF/ID register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  input  logic                       jump,
  input  logic [31:0]                jump_target,
  instruction_fetch_if.master        imem,
  output logic [31:0]                pc,
  output logic [31:0]                ifid_instr,
  output logic [31:0]                ifid_pc_plus4,
  output logic                       ifid_valid,
  output logic [31:0]                fetch_count
);
  import cpu_defs::*;

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [1:0]  w_sel;
  logic        w_flush;
  logic        w_count_en;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_flush    = branch_taken | jump;

  // Branch is the older instruction, so it beats a same-cycle jump.
  always_comb begin
    w_sel = SEL_SEQ;
    if (branch_taken)
      w_sel = SEL_BRANCH;
    else if (jump)
      w_sel = SEL_JUMP;
    else if (stall)
      w_sel = SEL_HOLD;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      SEL_BRANCH: w_pc_next = word_align(branch_target);
      SEL_JUMP:   w_pc_next = word_align(jump_target);
      SEL_HOLD:   w_pc_next = r_pc;
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else
      r_pc <= w_pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_fetch_count <= 32'h0000_0000;
    else if (w_count_en)
      r_fetch_count <= r_fetch_count + 32'd1;
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (w_flush),
    .instr        (imem.imem_instr),
    .pc_plus4     (w_pc_plus4),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .count_en     (w_count_en)
  );

  assign imem.imem_addr = {2'b00, r_pc[31:2]};
  assign pc             = r_pc;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven checks of the fetch stage against hand-computed
// PC / IF/ID / fetch_count values, plus a short stall-after-flush sequence.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  instruction_fetch_if imem_bus ();
  assign imem_bus.imem_instr = mem[imem_bus.imem_addr[5:0]];

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem         (imem_bus),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic rst, input logic stl,
                              input logic br, input logic [31:0] br_tgt,
                              input logic jmp, input logic [31:0] jmp_tgt,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_p4, input logic e_valid,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.br_tgt = br_tgt;
    v.jmp = jmp; v.jmp_tgt = jmp_tgt; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_p4 = e_p4; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input int idx, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [31:0] e_p4,
                             input logic e_valid, input logic [31:0] e_cnt);
    logic [31:0] e_addr;
    e_addr = {2'b00, e_pc[31:2]};
    chk("pc", idx, pc, e_pc);
    chk("imem_addr", idx, imem_bus.imem_addr, e_addr);
    chk("ifid_instr", idx, ifid_instr, e_instr);
    chk("ifid_pc_plus4", idx, ifid_pc_plus4, e_p4);
    chk("ifid_valid", idx, {31'd0, ifid_valid}, {31'd0, e_valid});
    chk("fetch_count", idx, fetch_count, e_cnt);
    $display("step %0d: pc=0x%08h ifid_instr=0x%08h pc4=0x%08h valid=%0b count=%0d",
             idx, pc, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic br,
                       input logic [31:0] br_tgt, input logic jmp,
                       input logic [31:0] jmp_tgt);
    reset = rst; stall = stl; branch_taken = br; branch_target = br_tgt;
    jump = jmp; jump_target = jmp_tgt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;
    for (int i = 4; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);

    //            rst  stl  br  br_tgt        jmp jmp_tgt       pc            instr          pc+4          v  cnt
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,32'h0000_0000, 32'h0000_0000,1'b0,32'd0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0004,32'h2008_0001, 32'h0000_0004,1'b1,32'd1);
    vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0008,32'h2009_0002, 32'h0000_0008,1'b1,32'd2);
    vecs[3]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0008,32'h2009_0002, 32'h0000_0008,1'b1,32'd2);
    vecs[4]  = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0008,32'h2009_0002, 32'h0000_0008,1'b1,32'd2);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_000C,32'h0109_5020, 32'h0000_000C,1'b1,32'd3);
    vecs[6]  = mk(1'b0,1'b0,1'b1,32'h40,      1'b0,32'h0,       32'h0000_0040,32'h0000_0000, 32'h0000_0000,1'b0,32'd3);
    vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0044,32'hA000_0010, 32'h0000_0044,1'b1,32'd4);
    vecs[8]  = mk(1'b0,1'b1,1'b1,32'h80,      1'b1,32'hC0,      32'h0000_0080,32'h0000_0000, 32'h0000_0000,1'b0,32'd4);
    vecs[9]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0084,32'hA000_0020, 32'h0000_0084,1'b1,32'd5);
    vecs[10] = mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h13,      32'h0000_0010,32'h0000_0000, 32'h0000_0000,1'b0,32'd5);
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0014,32'hA000_0004, 32'h0000_0014,1'b1,32'd6);
    vecs[12] = mk(1'b0,1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0014,32'hA000_0004, 32'h0000_0014,1'b1,32'd6);
    vecs[13] = mk(1'b1,1'b1,1'b1,32'h80,      1'b0,32'h0,       32'h0000_0000,32'h0000_0000, 32'h0000_0000,1'b0,32'd0);
    vecs[14] = mk(1'b0,1'b1,1'b0,32'h0,       1'b1,32'hFFFF_FFFE,32'hFFFF_FFFC,32'h0000_0000,32'h0000_0000,1'b0,32'd0);
    vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0000,32'hA000_003F, 32'h0000_0000,1'b1,32'd1);
    vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0000_0004,32'h2008_0001, 32'h0000_0004,1'b1,32'd2);

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].br_tgt,
            vecs[i].jmp, vecs[i].jmp_tgt);
      step();
      check_state(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4,
                  vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Misaligned branch, then a stall must keep the bubble, then resume.
    drive(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0);
    step();
    check_state(100, 32'h20, 32'h0, 32'h0, 1'b0, 32'd2);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_state(101, 32'h20, 32'h0, 32'h0, 1'b0, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_state(102, 32'h24, 32'hA000_0008, 32'h24, 1'b1, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the pipelined MIPS core.
- Holds the PC, drives the word address into the combinational instruction memory, and selects next-PC among sequential, branch and jump.
- Registers the fetched instruction into the IF/ID pipeline register.
- Supports stall (load-use hold) and flush (control-hazard bubble) from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- branch_taken  input  1  branch resolved taken; redirect to branch_target.
- branch_target  input  32  byte address of the branch destination.
- jump  input  1  jump decoded; redirect to jump_target.
- jump_target  input  32  byte address of the jump destination.
- imem_addr  output  32  word index into instruction memory, equal to {2'b00, pc[31:2]}.
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- pc  output  32  current fetch PC (byte address).
- ifid_instr  output  32  registered instruction for decode.
- ifid_pc_plus4  output  32  registered pc+4 of that instruction.
- ifid_valid  output  1  1 = ifid_instr is a real fetched instruction, 0 = bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Clocking: one clock (clk); reset is synchronous, active-high. All state updates on the rising edge of clk; no asynchronous paths.
- Reset (reset=1 at an edge), dominating every other input:
  - pc <= RESET_PC.
  - ifid_instr <= NOP_INSTR, ifid_pc_plus4 <= 0, ifid_valid <= 0.
  - fetch_count <= 0.
  - Reset asserted mid-stall or mid-redirect discards that pending action.
- Memory interface:
  - imem_addr is purely combinational from pc.
  - imem_instr is sampled in the same cycle, giving one-cycle fetch latency: an instruction at pc appears on ifid_instr the cycle after pc holds it.
- Redirect target alignment: target bits [1:0] are forced to 0 before loading into pc (misaligned targets are word-truncated, not trapped).
- Next-PC priority, highest first:
  1. reset.
  2. branch_taken: pc <= branch_target.
  3. jump: pc <= jump_target.
  4. stall: pc holds.
  5. Otherwise: pc <= pc + 4.
  - branch_taken wins over a simultaneous jump (the branch is the older instruction).
  - A redirect wins over stall.
- IF/ID update, same priority:
  - Redirect (branch_taken or jump): flush. ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc_plus4 <= 0.
  - stall with no redirect: IF/ID holds all fields, including ifid_valid.
  - Normal: ifid_instr <= imem_instr, ifid_pc_plus4 <= pc + 4, ifid_valid <= 1.
- fetch_count:
  - Increments by 1 only on a normal IF/ID load.
  - Unchanged on stall, flush or reset-exit.
  - Wraps modulo 2^32.
- Arithmetic: pc + 4 is 32-bit modulo. PC 32'hFFFF_FFFC advances to 32'h0000_0000 without error.
- Memory depth: out-of-depth addresses are the memory's concern; fetch does not clamp.

Decomposition:
- Shared package (cpu_defs): NOP_INSTR, RESET_PC default, and the next-PC select encoding (SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_HOLD) as localparams.
- One natural sub-module: if_id_reg.
  - Inputs: clk, reset, stall, flush, instr, pc_plus4.
  - Outputs: the three ifid_* signals plus fetch_count increment enable.
- The top level holds the PC register and next-PC mux.

Test Plan:
- Reset, then release with imem words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 -> pc steps 0,4,8,12; ifid_instr follows one cycle later; fetch_count = 4 after the 4th accept; imem_addr = 0,1,2,3.
- stall high for 2 cycles at pc=8 -> pc stays 8; ifid_instr holds 0x20090002; fetch_count is unchanged; pc resumes at 12 after release.
- branch_taken with branch_target=0x40 at pc=12 -> next pc=0x40; ifid_valid=0; ifid_instr=0; following cycle ifid_instr=mem[16].
- branch_taken (target 0x80) and jump (target 0xC0) in the same cycle, plus stall=1 -> pc=0x80 and IF/ID is flushed.
- jump_target=0x13 -> pc=0x10 (word-truncated); reset asserted during stall -> pc=RESET_PC, ifid_valid=0, fetch_count=0.
- Force pc to 0xFFFF_FFFC via jump -> next sequential pc=0x0000_0000; ifid_pc_plus4=0x0000_0000.
